// File: rtl/uart_rx_engine_p.sv
// Oversampled UART receive engine with majority voting, break and idle detection,
// and a first-word-fall-through receive FIFO carrying per-byte parity/framing status.
module uart_rx_engine_p #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned IDLE_BITS  = 20
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          acq_tick_i,
    input  logic                          rx_i,
    input  logic [1:0]                    data_len_i,
    input  logic                          parity_en_i,
    input  logic                          parity_odd_i,
    input  logic                          big_end_i,
    input  logic                          stop2_i,
    input  logic                          n_rd_i,
    input  logic                          n_clr_i,
    output logic [7:0]                    data_o,
    output logic [1:0]                    err_o,
    output logic                          p_empty_o,
    output logic                          p_full_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic [7:0]                    parity_err_cnt_o,
    output logic [7:0]                    frame_err_cnt_o,
    output logic [7:0]                    overrun_cnt_o,
    output logic                          p_byte_done_o,
    output logic                          break_o,
    output logic                          idle_o
);

    localparam int unsigned TW         = $clog2(OVERSAMPLE);
    localparam int unsigned AW         = $clog2(FIFO_DEPTH);
    localparam int unsigned LW         = AW + 1;
    localparam int unsigned MID        = OVERSAMPLE / 2;
    localparam int unsigned IDLE_TICKS = IDLE_BITS * OVERSAMPLE;
    localparam int unsigned IW         = $clog2(IDLE_TICKS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t state_q, state_d;

    logic          rx_s1, rx_s2, rx_prev;
    logic          fall;
    logic [TW-1:0] tc_q;
    logic          smp_a, smp_b;
    logic          maj, decide, bit_end;

    logic [1:0]    len_q;
    logic          par_en_q, par_odd_q, big_q, stop2_q;
    logic [2:0]    bit_cnt_q, last_bit, pos;
    logic [7:0]    shreg_q;
    logic          par_err_q, frm_err_q, zero_q, stop_cnt_q;

    logic          start_cap, put_bit, par_chk, stop_mid, adv_bit, adv_stop;
    logic          wr_en, brk_det;
    logic [1:0]    wr_err;

    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          full, empty, pop, push, ovr;
    logic [9:0]    head;

    logic [IW-1:0] idle_cnt_q;
    logic          idle_armed_q, idle_run, idle_fire;

    // Two-flop synchroniser plus edge history, all idling at line-high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx_i;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign fall     = rx_prev & ~rx_s2;
    assign decide   = acq_tick_i && (tc_q == TW'(MID + 1));
    assign bit_end  = acq_tick_i && (tc_q == TW'(OVERSAMPLE - 1));
    assign maj      = (smp_a & smp_b) | (smp_a & rx_s2) | (smp_b & rx_s2);
    assign last_bit = 3'd4 + {1'b0, len_q};
    assign pos      = big_q ? (last_bit - bit_cnt_q) : bit_cnt_q;
    assign wr_err   = {frm_err_q | ~maj, par_err_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        start_cap = 1'b0;
        put_bit   = 1'b0;
        par_chk   = 1'b0;
        stop_mid  = 1'b0;
        adv_bit   = 1'b0;
        adv_stop  = 1'b0;
        wr_en     = 1'b0;
        brk_det   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    state_d   = S_START;
                    start_cap = 1'b1;
                end
            end
            S_START: begin
                if (decide && maj)  state_d = S_IDLE;
                else if (bit_end)   state_d = S_DATA;
            end
            S_DATA: begin
                if (decide) put_bit = 1'b1;
                if (bit_end) begin
                    if (bit_cnt_q == last_bit) state_d = par_en_q ? S_PARITY : S_STOP;
                    else                       adv_bit = 1'b1;
                end
            end
            S_PARITY: begin
                if (decide)  par_chk = 1'b1;
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                // The final stop decision commits the byte; the rest of the bit is not awaited.
                if (decide) begin
                    if (!stop_cnt_q && zero_q && !maj) begin
                        brk_det = 1'b1;
                        state_d = S_BREAK;
                    end else if (stop_cnt_q == stop2_q) begin
                        wr_en   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        stop_mid = 1'b1;
                    end
                end else if (bit_end) begin
                    adv_stop = 1'b1;
                end
            end
            S_BREAK: begin
                if (rx_s2) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tc_q       <= '0;
            smp_a      <= 1'b1;
            smp_b      <= 1'b1;
            len_q      <= '0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            big_q      <= 1'b0;
            stop2_q    <= 1'b0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            zero_q     <= 1'b1;
            stop_cnt_q <= 1'b0;
        end else if (start_cap) begin
            tc_q       <= '0;
            len_q      <= data_len_i;
            par_en_q   <= parity_en_i;
            par_odd_q  <= parity_odd_i;
            big_q      <= big_end_i;
            stop2_q    <= stop2_i;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            zero_q     <= 1'b1;
            stop_cnt_q <= 1'b0;
        end else begin
            if (acq_tick_i && state_q != S_IDLE && state_q != S_BREAK) begin
                tc_q <= (tc_q == TW'(OVERSAMPLE - 1)) ? '0 : tc_q + TW'(1);
                if (tc_q == TW'(MID - 1)) smp_a <= rx_s2;
                if (tc_q == TW'(MID))     smp_b <= rx_s2;
            end
            if (put_bit) begin
                shreg_q[pos] <= maj;
                zero_q       <= zero_q & ~maj;
            end
            if (par_chk) begin
                par_err_q <= (^shreg_q) ^ maj ^ par_odd_q;
                zero_q    <= zero_q & ~maj;
            end
            if (stop_mid) frm_err_q  <= frm_err_q | ~maj;
            if (adv_bit)  bit_cnt_q  <= bit_cnt_q + 3'd1;
            if (adv_stop) stop_cnt_q <= 1'b1;
        end
    end

    assign full  = (level_q == LW'(FIFO_DEPTH));
    assign empty = (level_q == '0);
    assign pop   = ~n_rd_i & ~empty;
    assign push  = wr_en & (~full | pop);
    // A write lost to a same-cycle flush is not an overrun.
    assign ovr   = wr_en & full & ~pop & n_clr_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (!n_clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && n_clr_i) mem[wr_ptr_q] <= {wr_err, shreg_q};
    end

    assign head      = mem[rd_ptr_q];
    assign data_o    = empty ? '0 : head[7:0];
    assign err_o     = empty ? '0 : head[9:8];
    assign p_empty_o = empty;
    assign p_full_o  = full;
    assign level_o   = level_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_err_cnt_o <= '0;
            frame_err_cnt_o  <= '0;
            overrun_cnt_o    <= '0;
        end else begin
            if (wr_en && wr_err[0] && parity_err_cnt_o != 8'hFF)
                parity_err_cnt_o <= parity_err_cnt_o + 8'd1;
            if (wr_en && wr_err[1] && frame_err_cnt_o != 8'hFF)
                frame_err_cnt_o <= frame_err_cnt_o + 8'd1;
            if (ovr && overrun_cnt_o != 8'hFF)
                overrun_cnt_o <= overrun_cnt_o + 8'd1;
        end
    end

    assign idle_run  = acq_tick_i && state_q == S_IDLE && rx_s2 && idle_armed_q;
    assign idle_fire = idle_run && (idle_cnt_q == IW'(IDLE_TICKS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt_q   <= '0;
            idle_armed_q <= 1'b0;
        end else begin
            if (wr_en)          idle_armed_q <= 1'b1;
            else if (idle_fire) idle_armed_q <= 1'b0;
            if (wr_en || start_cap || idle_fire) idle_cnt_q <= '0;
            else if (idle_run)                   idle_cnt_q <= idle_cnt_q + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_byte_done_o <= 1'b0;
            break_o       <= 1'b0;
            idle_o        <= 1'b0;
        end else begin
            p_byte_done_o <= wr_en;
            break_o       <= brk_det;
            idle_o        <= idle_fire;
        end
    end

endmodule

// File: tb/tb_uart_rx_engine_p.sv
// Directed bench for uart_rx_engine_p: frames are built bit by bit at one
// acquisition tick per clock, with outputs checked against hand-computed values.
module tb_uart_rx_engine_p;

    localparam int OS    = 16;
    localparam int DEPTH = 4;
    localparam int IDLE  = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       acq_tick_i;
    logic       rx_i;
    logic [1:0] data_len_i;
    logic       parity_en_i, parity_odd_i, big_end_i, stop2_i;
    logic       n_rd_i, n_clr_i;
    logic [7:0] data_o;
    logic [1:0] err_o;
    logic       p_empty_o, p_full_o;
    logic [2:0] level_o;
    logic [7:0] parity_err_cnt_o, frame_err_cnt_o, overrun_cnt_o;
    logic       p_byte_done_o, break_o, idle_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_done = 0, n_break = 0, n_idle = 0;
    int done_cyc = 0, idle_cyc = 0;

    uart_rx_engine_p #(
        .OVERSAMPLE (OS),
        .FIFO_DEPTH (DEPTH),
        .IDLE_BITS  (IDLE)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .acq_tick_i       (acq_tick_i),
        .rx_i             (rx_i),
        .data_len_i       (data_len_i),
        .parity_en_i      (parity_en_i),
        .parity_odd_i     (parity_odd_i),
        .big_end_i        (big_end_i),
        .stop2_i          (stop2_i),
        .n_rd_i           (n_rd_i),
        .n_clr_i          (n_clr_i),
        .data_o           (data_o),
        .err_o            (err_o),
        .p_empty_o        (p_empty_o),
        .p_full_o         (p_full_o),
        .level_o          (level_o),
        .parity_err_cnt_o (parity_err_cnt_o),
        .frame_err_cnt_o  (frame_err_cnt_o),
        .overrun_cnt_o    (overrun_cnt_o),
        .p_byte_done_o    (p_byte_done_o),
        .break_o          (break_o),
        .idle_o           (idle_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (p_byte_done_o) begin n_done = n_done + 1; done_cyc = cyc; end
        if (break_o)       n_break = n_break + 1;
        if (idle_o)        begin n_idle = n_idle + 1; idle_cyc = cyc; end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cfg(input logic [1:0] len, input logic pen, input logic podd,
                       input logic big, input logic s2);
        data_len_i   = len;
        parity_en_i  = pen;
        parity_odd_i = podd;
        big_end_i    = big;
        stop2_i      = s2;
    endtask

    task automatic bit_time(input logic v);
        rx_i = v;
        repeat (OS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input logic big,
                              input logic par_en, input logic par_bit, input int nstop);
        bit_time(1'b0);
        for (int k = 0; k < nbits; k++) bit_time(big ? d[nbits-1-k] : d[k]);
        if (par_en) bit_time(par_bit);
        for (int k = 0; k < nstop; k++) bit_time(1'b1);
    endtask

    task automatic do_pop();
        n_rd_i = 1'b0;
        @(negedge clk);
        n_rd_i = 1'b1;
    endtask

    task automatic do_clr();
        n_clr_i = 1'b0;
        @(negedge clk);
        n_clr_i = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; rx_i = 1'b1; n_rd_i = 1'b1; n_clr_i = 1'b1; acq_tick_i = 1'b1;
        cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if ({p_empty_o, p_full_o, level_o} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_fifo: empty/full/level=%b required 10000", {p_empty_o, p_full_o, level_o});
        end
        checks++;
        if ({data_o, err_o} !== 10'h000) begin
            errors++;
            $display("FAIL reset_head: data=%h err=%b required 00/00", data_o, err_o);
        end
        checks++;
        if ({parity_err_cnt_o, frame_err_cnt_o, overrun_cnt_o} !== 24'h0) begin
            errors++;
            $display("FAIL reset_cnt: %h required 000000", {parity_err_cnt_o, frame_err_cnt_o, overrun_cnt_o});
        end
        checks++;
        if ({p_byte_done_o, break_o, idle_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_pulses: %b required 000", {p_byte_done_o, break_o, idle_o});
        end
        rst = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        int d0;
        cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        d0 = n_done;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1);
        checks++;
        if (n_done - d0 != 1) begin
            errors++;
            $display("FAIL basic_done: pulses=%0d required 1", n_done - d0);
        end
        checks++;
        if ({data_o, err_o, level_o} !== {8'hA5, 2'b00, 3'd1}) begin
            errors++;
            $display("FAIL basic_entry: data=%h err=%b level=%0d required a5/00/1", data_o, err_o, level_o);
        end
        do_pop();
        checks++;
        if ({p_empty_o, data_o} !== {1'b1, 8'h00}) begin
            errors++;
            $display("FAIL basic_pop: empty=%b data=%h required 1/00", p_empty_o, data_o);
        end
    endtask

    task automatic test_parity();
        cfg(2'b10, 1'b1, 1'b0, 1'b1, 1'b0);
        // 0x35 has four ones, so even parity is 0; send 1.
        send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1, 1);
        checks++;
        if ({data_o, err_o} !== {8'h35, 2'b01}) begin
            errors++;
            $display("FAIL parity_entry: data=%h err=%b required 35/01", data_o, err_o);
        end
        checks++;
        if ({parity_err_cnt_o, frame_err_cnt_o} !== {8'd1, 8'd0}) begin
            errors++;
            $display("FAIL parity_cnt: par=%0d frm=%0d required 1/0", parity_err_cnt_o, frame_err_cnt_o);
        end
        do_pop();
    endtask

    task automatic test_false_start();
        int d0, b0, i0;
        cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        d0 = n_done; b0 = n_break; i0 = n_idle;
        rx_i = 1'b0;
        repeat (4) @(negedge clk);
        rx_i = 1'b1;
        repeat (32) @(negedge clk);
        checks++;
        if ({n_done - d0, n_break - b0, n_idle - i0} !== {32'd0, 32'd0, 32'd0} || level_o !== 3'd0) begin
            errors++;
            $display("FAIL false_start: done=%0d break=%0d idle=%0d level=%0d required 0/0/0/0",
                     n_done - d0, n_break - b0, n_idle - i0, level_o);
        end
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1);
        checks++;
        if ({data_o, err_o, level_o} !== {8'h3C, 2'b00, 3'd1}) begin
            errors++;
            $display("FAIL false_start_next: data=%h err=%b level=%0d required 3c/00/1", data_o, err_o, level_o);
        end
        do_pop();
    endtask

    task automatic test_break();
        int d0, b0;
        cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        d0 = n_done; b0 = n_break;
        rx_i = 1'b0;
        repeat (12 * OS) @(negedge clk);
        checks++;
        if (n_break - b0 != 1 || n_done - d0 != 0) begin
            errors++;
            $display("FAIL break_pulse: break=%0d done=%0d required 1/0", n_break - b0, n_done - d0);
        end
        checks++;
        if ({level_o, frame_err_cnt_o} !== {3'd0, 8'd0}) begin
            errors++;
            $display("FAIL break_state: level=%0d frm=%0d required 0/0", level_o, frame_err_cnt_o);
        end
        rx_i = 1'b1;
        repeat (2 * OS) @(negedge clk);
        checks++;
        if (n_break - b0 != 1) begin
            errors++;
            $display("FAIL break_once: break=%0d required 1", n_break - b0);
        end
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1);
        checks++;
        if ({data_o, err_o, level_o} !== {8'h55, 2'b00, 3'd1}) begin
            errors++;
            $display("FAIL break_next: data=%h err=%b level=%0d required 55/00/1", data_o, err_o, level_o);
        end
        do_pop();
    endtask

    task automatic test_overrun();
        logic [7:0] exp;
        cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 6; i++) send_frame(8'(i), 8, 1'b0, 1'b0, 1'b0, 2);
        checks++;
        if ({p_full_o, level_o, overrun_cnt_o} !== {1'b1, 3'd4, 8'd2}) begin
            errors++;
            $display("FAIL overrun_state: full=%b level=%0d ovr=%0d required 1/4/2", p_full_o, level_o, overrun_cnt_o);
        end
        for (int i = 0; i < 4; i++) begin
            exp = 8'(i + 1);
            checks++;
            if ({data_o, err_o} !== {exp, 2'b00}) begin
                errors++;
                $display("FAIL overrun_pop%0d: data=%h err=%b required %h/00", i, data_o, err_o, exp);
            end
            do_pop();
        end
        checks++;
        if ({p_empty_o, level_o} !== {1'b1, 3'd0}) begin
            errors++;
            $display("FAIL overrun_drain: empty=%b level=%0d required 1/0", p_empty_o, level_o);
        end
        send_frame(8'h07, 8, 1'b0, 1'b0, 1'b0, 2);
        send_frame(8'h08, 8, 1'b0, 1'b0, 1'b0, 2);
        checks++;
        if ({level_o, data_o} !== {3'd2, 8'h07}) begin
            errors++;
            $display("FAIL refill: level=%0d data=%h required 2/07", level_o, data_o);
        end
        do_clr();
        checks++;
        if ({p_empty_o, level_o, data_o, overrun_cnt_o} !== {1'b1, 3'd0, 8'h00, 8'd2}) begin
            errors++;
            $display("FAIL clear: empty=%b level=%0d data=%h ovr=%0d required 1/0/00/2",
                     p_empty_o, level_o, data_o, overrun_cnt_o);
        end
    endtask

    task automatic test_idle();
        int i0, i1;
        cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        i0 = n_idle;
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b0, 1);
        send_frame(8'h33, 8, 1'b0, 1'b0, 1'b0, 1);
        for (int t = 0; t < 400 && n_idle == i0; t++) @(negedge clk);
        checks++;
        if (n_idle - i0 != 1 || idle_cyc - done_cyc != IDLE * OS) begin
            errors++;
            $display("FAIL idle_gap: pulses=%0d delay=%0d required 1/%0d", n_idle - i0, idle_cyc - done_cyc, IDLE * OS);
        end
        repeat (400) @(negedge clk);
        checks++;
        if (n_idle - i0 != 1) begin
            errors++;
            $display("FAIL idle_once: pulses=%0d required 1", n_idle - i0);
        end
        do_clr();
        i1 = n_idle;
        send_frame(8'h44, 8, 1'b0, 1'b0, 1'b0, 1);
        while (cyc < done_cyc + 290) @(negedge clk);
        send_frame(8'h66, 8, 1'b0, 1'b0, 1'b0, 1);
        checks++;
        if (n_idle != i1) begin
            errors++;
            $display("FAIL idle_restart: pulses=%0d required 0", n_idle - i1);
        end
        for (int t = 0; t < 400 && n_idle == i1; t++) @(negedge clk);
        checks++;
        if (n_idle - i1 != 1 || idle_cyc - done_cyc != IDLE * OS) begin
            errors++;
            $display("FAIL idle_rearm: pulses=%0d delay=%0d required 1/%0d", n_idle - i1, idle_cyc - done_cyc, IDLE * OS);
        end
    endtask

    task automatic test_mid_reset();
        int d0;
        cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        rx_i = 1'b0;
        repeat (3 * OS) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({p_empty_o, level_o, parity_err_cnt_o, overrun_cnt_o} !== {1'b1, 3'd0, 8'd0, 8'd0}) begin
            errors++;
            $display("FAIL mid_reset: empty=%b level=%0d par=%0d ovr=%0d required 1/0/0/0",
                     p_empty_o, level_o, parity_err_cnt_o, overrun_cnt_o);
        end
        rx_i = 1'b1;
        rst = 1'b1;
        repeat (20) @(negedge clk);
        d0 = n_done;
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1);
        checks++;
        if ({data_o, err_o, level_o} !== {8'h5A, 2'b00, 3'd1} || n_done - d0 != 1) begin
            errors++;
            $display("FAIL mid_reset_next: data=%h err=%b level=%0d done=%0d required 5a/00/1/1",
                     data_o, err_o, level_o, n_done - d0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_false_start();
        test_break();
        test_overrun();
        test_idle();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
